// File: rtl/nibble_serial_alu_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add/sub controller.
// State encoding is fixed so it stays readable in waveforms.
package nibble_serial_alu_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_alu_ctrl_adder4.sv
// 4-bit ripple-carry adder slice.
// Shared by the controller, one nibble per clock.
module adder4
  import nibble_serial_alu_ctrl_pkg::*;
(
  input  logic             carryin,
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  output logic [NIB_W-1:0] s,
  output logic             carryout
);

  logic [NIB_W:0] w_c;

  always_comb begin
    w_c    = '0;
    s      = '0;
    w_c[0] = carryin;
    for (int i = 0; i < NIB_W; i++) begin
      s[i]     = x[i] ^ y[i] ^ w_c[i];
      w_c[i+1] = (x[i] & y[i]) |
                 (w_c[i] & (x[i] ^ y[i]));
    end
  end

  assign carryout = w_c[NIB_W];

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// N-bit add/sub built by walking one shared 4-bit adder
// across the operands, LSB nibble first.
module nibble_serial_alu_ctrl
  import nibble_serial_alu_ctrl_pkg::*;
#(
  parameter  int NIBBLES = 4,
  localparam int W       = NIB_W * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         op_sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int SW = KW + 2;

  state_e r_state;
  state_e w_state_nxt;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_result;
  logic             r_sub;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [KW-1:0]    r_k;

  logic [SW-1:0]    w_sh;
  logic [W-1:0]     w_a_sh;
  logic [W-1:0]     w_b_sh;
  logic [NIB_W-1:0] w_x;
  logic [NIB_W-1:0] w_y;
  logic [NIB_W-1:0] w_s;
  logic             w_co;
  logic             w_last;
  logic             w_accept;
  logic             w_ymsb;

  assign w_sh   = {r_k, 2'b00};
  assign w_a_sh = r_a >> w_sh;
  assign w_b_sh = r_b >> w_sh;
  assign w_x    = w_a_sh[NIB_W-1:0];
  assign w_y    = w_b_sh[NIB_W-1:0] ^ {NIB_W{r_sub}};
  assign w_last = (r_k == KW'(NIBBLES - 1));
  assign w_ymsb = r_b[W-1] ^ r_sub;

  // Start is ignored while a nibble walk is in flight.
  assign w_accept = start && (r_state != ST_RUN);

  adder4 u_adder4 (
    .carryin  (r_carry),
    .x        (w_x),
    .y        (w_y),
    .s        (w_s),
    .carryout (w_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (start)  w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = start ? ST_RUN : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_k      <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_sub    <= op_sub;
      r_carry  <= op_sub;
      r_k      <= '0;
      r_result <= '0;
    end else if (r_state == ST_RUN) begin
      r_result[w_sh +: NIB_W] <= w_s;
      r_carry <= w_co;
      r_k     <= r_k + KW'(1);
      // Last nibble's sum holds the result MSB.
      if (w_last) begin
        r_cout <= w_co;
        r_ovf  <= (r_a[W-1] == w_ymsb) &&
                  (w_s[NIB_W-1] != r_a[W-1]);
      end
    end
  end

  assign busy   = (r_state == ST_RUN);
  assign done   = (r_state == ST_DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule
